// File: rtl/rom_fetch_cache.sv
// rom_fetch_cache
//   Per-client ROM front end. It maps a client address, counted in
//   ROM_DATA_WIDTH words, to a 23-bit SDRAM 32-bit-word address. Repeat reads
//   are served from a small direct-mapped cache of 32-bit words. A miss runs a
//   req/ack/valid handshake with the ROM arbiter. Client data is returned
//   either as a zero-latency hit or in the cycle the SDRAM read completes.
//
// Ports
//   clk, reset            single clock; asynchronous active-high reset
//   cs, oe, rom_addr      client select, read strobe and address
//   rom_data              client data (combinational)
//   flush                 invalidate every cache line
//   ctrl_addr, ctrl_req   SDRAM word address and read request to the arbiter
//   ctrl_ack, ctrl_valid  arbiter accept pulse and read-data-valid pulse
//   ctrl_data             SDRAM read data
//   ctrl_hit              rom_data is being served from the cache this cycle
module rom_fetch_cache #(
  parameter int unsigned ROM_ADDR_WIDTH = 16,
  parameter int unsigned ROM_DATA_WIDTH = 32,
  parameter logic [23:0] ROM_OFFSET     = 24'h000000,
  parameter int unsigned LINES          = 4
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic                      cs,
  input  logic                      oe,
  input  logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic [ROM_DATA_WIDTH-1:0] rom_data,
  input  logic                      flush,
  output logic [22:0]               ctrl_addr,
  output logic                      ctrl_req,
  input  logic                      ctrl_ack,
  input  logic                      ctrl_valid,
  output logic                      ctrl_hit,
  input  logic [31:0]               ctrl_data
);

  localparam int unsigned R  = 32 / ROM_DATA_WIDTH;
  localparam int unsigned S  = $clog2(R);
  localparam int unsigned LW = (S > 0) ? S : 1;
  localparam int unsigned IW = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0] line_valid;
  logic [22:0]      line_tag  [LINES];
  logic [31:0]      line_data [LINES];

  logic [22:0]   target;
  logic [LW-1:0] lane;
  logic [LW-1:0] lane_q;
  logic [IW-1:0] look_idx;
  logic [IW-1:0] fill_idx;
  logic          hit;
  logic          fill_done;

  function automatic logic [ROM_DATA_WIDTH-1:0] pick_lane(input logic [31:0] w,
                                                          input logic [LW-1:0] l);
    return w[int'(l)*ROM_DATA_WIDTH +: ROM_DATA_WIDTH];
  endfunction

  assign target   = {1'b0, ROM_OFFSET[23:2]} + 23'(rom_addr >> S);
  assign lane     = (S > 0) ? rom_addr[LW-1:0] : '0;
  assign look_idx = (LINES > 1) ? target[IW-1:0] : '0;
  assign fill_idx = (LINES > 1) ? ctrl_addr[IW-1:0] : '0;

  assign hit = line_valid[look_idx] && (line_tag[look_idx] == target);

  // An ack and valid arriving together in REQ complete the fill directly.
  assign fill_done = ctrl_valid &&
                     ((state == ST_WAIT) || ((state == ST_REQ) && ctrl_ack));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ctrl_addr <= '0;
      lane_q    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && cs && oe && !hit) begin
        ctrl_addr <= target;
        lane_q    <= lane;
      end
    end
  end

  // Flush wins over a coinciding fill: the line stays invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_valid <= '0;
    end else if (flush) begin
      line_valid <= '0;
    end else if (fill_done) begin
      line_valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done && !flush) begin
      line_tag[fill_idx]  <= ctrl_addr;
      line_data[fill_idx] <= ctrl_data;
    end
  end

  always_comb begin
    state_next = state;
    ctrl_req   = 1'b0;
    ctrl_hit   = 1'b0;
    rom_data   = '0;
    case (state)
      ST_IDLE: begin
        if (cs && oe) begin
          if (hit) begin
            ctrl_hit = 1'b1;
            rom_data = pick_lane(line_data[look_idx], lane);
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        ctrl_req = 1'b1;
        if (ctrl_ack) begin
          state_next = ST_WAIT;
          if (ctrl_valid) begin
            rom_data   = pick_lane(ctrl_data, lane_q);
            state_next = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (ctrl_valid) begin
          rom_data   = pick_lane(ctrl_data, lane_q);
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/rom_fetch_cache.md
# rom_fetch_cache

Per-client ROM front end between a video/CPU/sound ROM consumer and the ROM arbiter. It translates a client address in units of ROM_DATA_WIDTH into a 23-bit SDRAM 32-bit-word address. It serves repeat reads from a small direct-mapped cache of 32-bit words, and on a miss runs a req/ack/valid handshake with the arbiter. Client data is returned either as a zero-latency hit or in the cycle the SDRAM read completes.

## Interface
- ROM_ADDR_WIDTH, 16: client address width, in client words.
- ROM_DATA_WIDTH, 32: client word width; 8, 16 or 32 only.
- ROM_OFFSET, 24'h000000: byte base of this ROM in SDRAM; 4-byte aligned.
- LINES, 4: cache lines, each one 32-bit word; power of two, at least 1.
- reset  in  1  asynchronous, active-high.
- clk  in  1  the single clock.
- cs  in  1  client select; already gated low during ROM download.
- oe  in  1  client read strobe.
- rom_addr  in  ROM_ADDR_WIDTH  client address.
- rom_data  out  ROM_DATA_WIDTH  client data, combinational.
- flush  in  1  invalidate all lines; pulsed after each ROM download.
- ctrl_addr  out  23  SDRAM word address of the outstanding miss.
- ctrl_req  out  1  read request to the arbiter.
- ctrl_ack  in  1  request accepted; one-cycle pulse.
- ctrl_valid  in  1  ctrl_data valid; one-cycle pulse.
- ctrl_hit  out  1  rom_data is valid from the cache this cycle.
- ctrl_data  in  32  SDRAM read data.

## Operation
- R = 32/ROM_DATA_WIDTH lanes per word; S = log2(R).
- word = rom_addr >> S. lane = rom_addr[S-1:0], or 0 when S = 0.
- Target address = ROM_OFFSET[23:2] + word, truncated to 23 bits; wraps silently.
- Lane k occupies bits [k*W+W-1 : k*W]. Lane 0 is the lowest-addressed byte(s).
- Line index = target[log2(LINES)-1:0]. Each line stores a valid bit, the full 23-bit target as tag, and 32 data bits.
- Lookup hits when the indexed line is valid and its tag equals the target.
- FSM states:
  - IDLE:
    - cs & oe & hit: ctrl_hit = 1; rom_data = lane of the cached word.
    - cs & oe & miss: latch target into ctrl_addr and lane into a lane register; next state REQ.
  - REQ: ctrl_req = 1 and ctrl_addr held, regardless of cs. On ctrl_ack, next state WAIT.
  - WAIT: ctrl_req = 0. On ctrl_valid:
    - write ctrl_data and its tag into the line indexed by ctrl_addr and set valid;
    - rom_data = ctrl_data lane chosen by the latched lane, combinationally in that cycle;
    - next state IDLE.
- ctrl_hit is 0 outside IDLE.
- ctrl_valid in IDLE or REQ is ignored; no line is written.
- cs or oe dropping in REQ/WAIT does not abort. The fill completes and is cached.
- rom_addr changing in REQ/WAIT has no effect on the outstanding fill. The new address is looked up after return to IDLE.
- flush clears every valid bit in any state.
  - A fill whose ctrl_valid coincides with flush is not written, but its data is still presented on rom_data.
- rom_data is 0 when not hitting and not completing a fill.

## Timing
- Reset values: state IDLE, all lines invalid, ctrl_req 0, ctrl_addr 0, ctrl_hit 0, rom_data 0. The data and tag arrays need no reset.
- Reset mid-REQ/WAIT: immediate return to IDLE, ctrl_req drops asynchronously. A later stray ctrl_valid is ignored.
- Hit latency: 0 cycles; ctrl_hit is combinational from cs, oe, rom_addr and the cache contents.
- Miss timeline:
  - cycle N: miss detected.
  - cycle N+1: ctrl_req rises (registered).
  - ctrl_req stays high through the ack cycle and falls the cycle after ack.
  - Data is delivered in the ctrl_valid cycle.
  - Back in IDLE at cycle valid+1, where a hit on the same address asserts ctrl_hit.
- ack and valid in the same cycle while in REQ: treat as ack then valid, i.e. the fill completes and next state is IDLE.
- At most one outstanding request.

## Test plan
- Setup: W=16, ROM_OFFSET=24'h040000, LINES=4. Miss on rom_addr=3 -> ctrl_addr=23'h010001, ctrl_req from next cycle until ack. ctrl_valid with ctrl_data=32'hBEEF1234 -> rom_data=16'hBEEF that cycle.
- Then rom_addr=2 -> ctrl_hit=1 and rom_data=16'h1234 with no request. rom_addr=3 -> 16'hBEEF.
- Conflict: rom_addr=10 (word 5, line 1) -> new request to 23'h010005. Afterwards rom_addr=3 misses again.
- W=8 with ROM_OFFSET=24'h0d0000: rom_addr=7 -> ctrl_addr=23'h034001, lane 3. ctrl_data=32'hAABBCCDD -> rom_data=8'hAA.
- cs drops in WAIT and rom_addr changes -> fill still cached. flush asserted in the same cycle as ctrl_valid -> the next read to that address misses.
- Reset asserted in REQ -> ctrl_req low immediately. A later ctrl_valid causes no write and ctrl_hit stays 0.
